// File: rtl/text_console_pkg.sv
// Shared definitions for the text console writer: control codes, FSM encoding
// and small helpers used by the writer and its clear sequencer.
package text_console_pkg;

  localparam logic [6:0] CHAR_BS    = 7'h08;
  localparam logic [6:0] CHAR_LF    = 7'h0A;
  localparam logic [6:0] CHAR_FF    = 7'h0C;
  localparam logic [6:0] CHAR_CR    = 7'h0D;
  localparam logic [6:0] CHAR_SPACE = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CLR    = 2'd3
  } state_t;

  // Codes that produce a glyph write: 0x20..0x7E.
  function automatic logic is_printable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

  // Row after y, wrapping to the top instead of scrolling.
  function automatic logic [4:0] row_after(input logic [4:0] y, input logic [4:0] y_max);
    return (y == y_max) ? 5'd0 : y + 5'd1;
  endfunction

endpackage

// File: rtl/text_clear_sequencer.sv
// Steps through cells to blank them: either one row (x = 0..COLS-1) or the
// whole screen in row-major order. Each cell gets one strobe in a cycle where
// busy is low, followed by one settle cycle before the next cell.
module text_clear_sequencer
  import text_console_pkg::*;
#(
  parameter int COLS = 60,
  parameter int ROWS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_screen,
  input  logic [4:0] i_row,
  input  logic       i_busy,
  output logic       o_active,
  output logic       o_strobe,
  output logic       o_last,
  output logic [6:0] o_x,
  output logic [4:0] o_y
);

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

  logic       r_active;
  logic       r_settle;
  logic       r_screen;
  logic [6:0] r_x;
  logic [4:0] r_y;
  logic       w_last_cell;

  assign w_last_cell = (r_x == X_MAX) && (!r_screen || (r_y == Y_MAX));
  assign o_active    = r_active;
  assign o_strobe    = r_active && !r_settle && !i_busy;
  assign o_last      = o_strobe && w_last_cell;
  assign o_x         = r_x;
  assign o_y         = r_y;

  // Cell walk: start latches the mode, each accepted strobe advances or ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_settle <= 1'b0;
      r_screen <= 1'b0;
      r_x      <= 7'd0;
      r_y      <= 5'd0;
    end else if (!r_active) begin
      if (i_start) begin
        r_active <= 1'b1;
        r_settle <= 1'b0;
        r_screen <= i_screen;
        r_x      <= 7'd0;
        r_y      <= i_screen ? 5'd0 : i_row;
      end
    end else if (r_settle) begin
      r_settle <= 1'b0;
    end else if (!i_busy) begin
      if (w_last_cell) begin
        r_active <= 1'b0;
      end else begin
        r_settle <= 1'b1;
        if (r_x == X_MAX) begin
          r_x <= 7'd0;
          r_y <= r_y + 5'd1;
        end else begin
          r_x <= r_x + 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Terminal-style front end for the text buffer: accepts characters on a
// valid/ready stream, keeps a cursor, and turns printable codes and
// CR/LF/BS/FF into busy-paced single-cell writes.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int COLS           = 60,
  parameter int ROWS           = 20,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_char,
  input  logic [11:0] in_color,
  input  logic        in_lang,
  input  logic        busy,
  output logic        write_enable,
  output logic [6:0]  write_x,
  output logic [4:0]  write_y,
  output logic [6:0]  write_data,
  output logic [11:0] write_text_color,
  output logic        write_lang,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y
);

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

  state_t      r_state;
  state_t      w_state_next;

  logic [6:0]  r_cx;
  logic [4:0]  r_cy;
  logic [6:0]  r_nx;
  logic [4:0]  r_ny;
  logic [6:0]  r_wx;
  logic [4:0]  r_wy;
  logic [6:0]  r_wdata;
  logic [11:0] r_color;
  logic        r_lang;
  logic        r_pend_clr;
  logic        r_clr_screen;
  logic [4:0]  r_clr_row;

  logic        w_seq_start;
  logic        w_seq_active;
  logic        w_seq_strobe;
  logic        w_seq_last;
  logic [6:0]  w_seq_x;
  logic [4:0]  w_seq_y;
  logic [4:0]  w_row_next;
  logic        w_bs_moves;

  assign w_row_next = row_after(r_cy, Y_MAX);
  assign w_bs_moves = (r_cx != 7'd0) || (r_cy != 5'd0);
  assign cursor_x   = r_cx;
  assign cursor_y   = r_cy;

  text_clear_sequencer #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_clear (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_seq_start),
    .i_screen (r_clr_screen),
    .i_row    (r_clr_row),
    .i_busy   (busy),
    .o_active (w_seq_active),
    .o_strobe (w_seq_strobe),
    .o_last   (w_seq_last),
    .o_x      (w_seq_x),
    .o_y      (w_seq_y)
  );

  // State register; power-up clear is entered straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLR : ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, handshake and write port; strobes only ever leave when busy is low.
  always_comb begin
    w_state_next     = r_state;
    in_ready         = 1'b0;
    write_enable     = 1'b0;
    write_x          = 7'd0;
    write_y          = 5'd0;
    write_data       = 7'd0;
    write_text_color = 12'd0;
    write_lang       = 1'b0;
    w_seq_start      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_printable(in_char)) begin
            w_state_next = ST_ISSUE;
          end else begin
            case (in_char)
              CHAR_LF, CHAR_FF: w_state_next = ST_CLR;
              CHAR_BS:          w_state_next = w_bs_moves ? ST_ISSUE : ST_IDLE;
              default:          w_state_next = ST_IDLE;
            endcase
          end
        end
      end
      ST_ISSUE: begin
        if (!busy) begin
          write_enable     = 1'b1;
          write_x          = r_wx;
          write_y          = r_wy;
          write_data       = r_wdata;
          write_text_color = r_color;
          write_lang       = r_lang;
          w_state_next     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_state_next = r_pend_clr ? ST_CLR : ST_IDLE;
      end
      ST_CLR: begin
        w_seq_start = !w_seq_active;
        if (w_seq_strobe) begin
          write_enable     = 1'b1;
          write_x          = w_seq_x;
          write_y          = w_seq_y;
          write_data       = CHAR_SPACE;
          write_text_color = r_color;
          write_lang       = r_lang;
        end
        if (w_seq_last) begin
          w_state_next = ST_SETTLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (reset) begin
      in_ready         = 1'b0;
      write_enable     = 1'b0;
      write_x          = 7'd0;
      write_y          = 5'd0;
      write_data       = 7'd0;
      write_text_color = 12'd0;
      write_lang       = 1'b0;
    end
  end

  // Command decode on acceptance; the cursor commits after an operation's last strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cx         <= 7'd0;
      r_cy         <= 5'd0;
      r_nx         <= 7'd0;
      r_ny         <= 5'd0;
      r_wx         <= 7'd0;
      r_wy         <= 5'd0;
      r_wdata      <= 7'd0;
      r_color      <= 12'd0;
      r_lang       <= 1'b0;
      r_pend_clr   <= 1'b0;
      r_clr_screen <= 1'b1;
      r_clr_row    <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_color    <= in_color;
            r_lang     <= in_lang;
            r_pend_clr <= 1'b0;
            if (is_printable(in_char)) begin
              r_wx    <= r_cx;
              r_wy    <= r_cy;
              r_wdata <= in_char;
              if (r_cx == X_MAX) begin
                r_pend_clr   <= 1'b1;
                r_clr_screen <= 1'b0;
                r_clr_row    <= w_row_next;
                r_nx         <= 7'd0;
                r_ny         <= w_row_next;
              end else begin
                r_nx <= r_cx + 7'd1;
                r_ny <= r_cy;
              end
            end else begin
              case (in_char)
                CHAR_LF: begin
                  r_clr_screen <= 1'b0;
                  r_clr_row    <= w_row_next;
                  r_nx         <= r_cx;
                  r_ny         <= w_row_next;
                end
                CHAR_FF: begin
                  r_clr_screen <= 1'b1;
                  r_nx         <= 7'd0;
                  r_ny         <= 5'd0;
                end
                CHAR_CR: begin
                  r_cx <= 7'd0;
                end
                CHAR_BS: begin
                  r_wdata <= CHAR_SPACE;
                  if (r_cx != 7'd0) begin
                    r_wx <= r_cx - 7'd1;
                    r_wy <= r_cy;
                    r_nx <= r_cx - 7'd1;
                    r_ny <= r_cy;
                  end else if (r_cy != 5'd0) begin
                    r_wx <= X_MAX;
                    r_wy <= r_cy - 5'd1;
                    r_nx <= X_MAX;
                    r_ny <= r_cy - 5'd1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        ST_ISSUE: begin
          if (!busy && !r_pend_clr) begin
            r_cx <= r_nx;
            r_cy <= r_ny;
          end
        end
        ST_SETTLE: begin
          r_pend_clr <= 1'b0;
        end
        ST_CLR: begin
          if (w_seq_last) begin
            r_cx <= r_nx;
            r_cy <= r_ny;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: a queue-based screen-terminal model predicts
// every write and the resting cursor; directed sequences pin literal values.
module tb_text_console_writer;

  localparam int COLS = 60;
  localparam int ROWS = 20;

  typedef struct packed {
    logic [6:0]  x;
    logic [4:0]  y;
    logic [6:0]  d;
    logic [11:0] c;
    logic        l;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_char = 7'd0;
  logic [11:0] in_color = 12'd0;
  logic        in_lang = 1'b0;
  logic        busy = 1'b0;
  logic        write_enable;
  logic [6:0]  write_x;
  logic [4:0]  write_y;
  logic [6:0]  write_data;
  logic [11:0] write_text_color;
  logic        write_lang;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  logic busy_rand_en = 1'b0;
  logic busy_force   = 1'b0;

  wr_t  exp_q[$];
  int   m_x = 0, m_y = 0;
  int   n_tests = 0, n_fail = 0;
  int   g_cyc = 0, g_nstrobe = 0, g_acc_cyc = 0, g_last_cyc = 0;
  wr_t  g_last = '0;
  logic m_prev_we = 1'b0, m_prev_rst = 1'b1;

  always #5 clk = ~clk;

  text_console_writer #(
    .COLS           (COLS),
    .ROWS           (ROWS),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_char          (in_char),
    .in_color         (in_color),
    .in_lang          (in_lang),
    .busy             (busy),
    .write_enable     (write_enable),
    .write_x          (write_x),
    .write_y          (write_y),
    .write_data       (write_data),
    .write_text_color (write_text_color),
    .write_lang       (write_lang),
    .cursor_x         (cursor_x),
    .cursor_y         (cursor_y)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void report_timeout(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no progress within cycle budget (t=%0t)", name, $time);
  endfunction

  // ---------------- behavioural terminal model ----------------
  function automatic void push_cell(int x, int y, logic [6:0] d, logic [11:0] c, logic l);
    wr_t w;
    w.x = 7'(x); w.y = 5'(y); w.d = d; w.c = c; w.l = l;
    exp_q.push_back(w);
  endfunction

  function automatic void push_row(int y, logic [11:0] c, logic l);
    for (int x = 0; x < COLS; x++) push_cell(x, y, 7'h20, c, l);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_x = 0;
    m_y = 0;
    for (int y = 0; y < ROWS; y++) push_row(y, 12'h000, 1'b0);
  endfunction

  function automatic void model_accept(logic [6:0] ch, logic [11:0] c, logic l);
    if (ch >= 7'h20 && ch <= 7'h7E) begin
      push_cell(m_x, m_y, ch, c, l);
      if (m_x == COLS - 1) begin
        m_x = 0;
        m_y = (m_y + 1) % ROWS;
        push_row(m_y, c, l);
      end else begin
        m_x++;
      end
    end else if (ch == 7'h0A) begin
      m_y = (m_y + 1) % ROWS;
      push_row(m_y, c, l);
    end else if (ch == 7'h0D) begin
      m_x = 0;
    end else if (ch == 7'h08) begin
      if (m_x > 0) begin
        m_x--;
        push_cell(m_x, m_y, 7'h20, c, l);
      end else if (m_y > 0) begin
        m_x = COLS - 1;
        m_y--;
        push_cell(m_x, m_y, 7'h20, c, l);
      end
    end else if (ch == 7'h0C) begin
      for (int y = 0; y < ROWS; y++) push_row(y, c, l);
      m_x = 0;
      m_y = 0;
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    wr_t got, want;
    g_cyc++;
    if (reset) begin
      check("we_during_reset", write_enable, 0);
      model_reset();
    end else begin
      if (m_prev_rst) check("we_after_reset", write_enable, 0);
      if (write_enable) begin
        check("strobe_busy_low", busy, 0);
        check("strobe_spacing", m_prev_we, 0);
        got = {write_x, write_y, write_data, write_text_color, write_lang};
        check("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          check("write_fields", got, want);
        end
        g_nstrobe++;
        g_last     = got;
        g_last_cyc = g_cyc;
      end
      if (in_ready) begin
        check("pending_writes", exp_q.size(), 0);
        check("cursor_x", cursor_x, m_x);
        check("cursor_y", cursor_y, m_y);
      end
      if (in_valid && in_ready) begin
        model_accept(in_char, in_color, in_lang);
        g_acc_cyc = g_cyc;
      end
    end
    m_prev_we  = write_enable;
    m_prev_rst = reset;
  end

  // busy driver: either forced or randomized
  initial begin
    forever begin
      @(posedge clk);
      #1;
      busy = busy_rand_en ? ($urandom_range(0, 3) == 0) : busy_force;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] c, input logic [11:0] col, input logic l);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    in_char  = c;
    in_color = col;
    in_lang  = l;
    in_valid = 1'b1;
    while (!got && n < 10000) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) report_timeout("send_accept");
  endtask

  task automatic wait_idle(input int limit);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      @(negedge clk);
      got = in_ready;
      n++;
    end
    @(posedge clk);
    #1;
    if (!got) report_timeout("wait_idle");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   ff_left;
    bit   seen_ready;
    bit   hit;
    logic [6:0] ch;
    int   r;

    // 1. power-up clear
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    base = g_nstrobe;
    wait_idle(5000);
    check("pwrup_strobes", g_nstrobe - base, 1200);
    check("pwrup_last", g_last, {7'd59, 5'd19, 7'h20, 12'h000, 1'b0});
    check("pwrup_cursor", {cursor_x, cursor_y}, {7'd0, 5'd0});

    // 2. single printable, latency N+1
    base = g_nstrobe;
    send(7'h41, 12'hF00, 1'b1);
    wait_idle(100);
    check("A_strobes", g_nstrobe - base, 1);
    check("A_latency", g_last_cyc - g_acc_cyc, 1);
    check("A_write", g_last, {7'd0, 5'd0, 7'h41, 12'hF00, 1'b1});
    check("A_cursor", {cursor_x, cursor_y}, {7'd1, 5'd0});

    // 3. CR, then a full line wraps and clears row 1; LF at row 19 wraps to 0
    base = g_nstrobe;
    send(7'h0D, 12'h123, 1'b0);
    wait_idle(100);
    check("CR_strobes", g_nstrobe - base, 0);
    check("CR_cursor", {cursor_x, cursor_y}, {7'd0, 5'd0});
    base = g_nstrobe;
    for (int i = 0; i < 60; i++) send(7'h78, 12'h0F0, 1'b0);
    wait_idle(1000);
    check("line_strobes", g_nstrobe - base, 120);
    check("line_last", g_last, {7'd59, 5'd1, 7'h20, 12'h0F0, 1'b0});
    check("line_cursor", {cursor_x, cursor_y}, {7'd0, 5'd1});
    for (int i = 0; i < 18; i++) send(7'h0A, 12'h00F, 1'b0);
    wait_idle(1000);
    check("lf_row19", cursor_y, 19);
    base = g_nstrobe;
    send(7'h0A, 12'h00F, 1'b1);
    wait_idle(1000);
    check("lfwrap_strobes", g_nstrobe - base, 60);
    check("lfwrap_last", g_last, {7'd59, 5'd0, 7'h20, 12'h00F, 1'b1});
    check("lfwrap_cursor", {cursor_x, cursor_y}, {7'd0, 5'd0});

    // 4. BS at origin is a no-op; BS at (0,3) steps back to the previous row
    base = g_nstrobe;
    send(7'h08, 12'hFFF, 1'b0);
    wait_idle(100);
    check("bs00_strobes", g_nstrobe - base, 0);
    check("bs00_cursor", {cursor_x, cursor_y}, {7'd0, 5'd0});
    for (int i = 0; i < 3; i++) send(7'h0A, 12'h00F, 1'b0);
    wait_idle(1000);
    base = g_nstrobe;
    send(7'h08, 12'hABC, 1'b1);
    wait_idle(100);
    check("bs03_strobes", g_nstrobe - base, 1);
    check("bs03_write", g_last, {7'd59, 5'd2, 7'h20, 12'hABC, 1'b1});
    check("bs03_cursor", {cursor_x, cursor_y}, {7'd59, 5'd2});

    // 5. busy held high stalls a char write
    send(7'h0D, 12'h000, 1'b0);
    wait_idle(100);
    busy_force = 1'b1;
    tick();
    base = g_nstrobe;
    send(7'h51, 12'h5A5, 1'b0);
    seen_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) seen_ready = 1'b1;
    end
    check("busy_in_ready", seen_ready, 0);
    check("busy_no_strobe", g_nstrobe - base, 0);
    tick();
    busy_force = 1'b0;
    wait_idle(100);
    check("busy_one_strobe", g_nstrobe - base, 1);
    check("busy_write", g_last, {7'd0, 5'd2, 7'h51, 12'h5A5, 1'b0});
    check("busy_cursor", {cursor_x, cursor_y}, {7'd1, 5'd2});

    // random phase against the model
    busy_rand_en = 1'b1;
    ff_left = 1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      r = $urandom_range(0, 99);
      if (r < 70)      ch = 7'($urandom_range(32, 126));
      else if (r < 75) ch = 7'h0A;
      else if (r < 82) ch = 7'h0D;
      else if (r < 90) ch = 7'h08;
      else if (r < 91 && ff_left > 0) begin
        ch = 7'h0C;
        ff_left--;
      end else begin
        r = $urandom_range(0, 32);
        ch = (r == 32) ? 7'h7F : 7'(r);
      end
      send(ch, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
    end
    wait_idle(20000);
    busy_rand_en = 1'b0;
    tick();

    // 6. FF aborted by reset after 300 strobes
    base = g_nstrobe;
    send(7'h0C, 12'h777, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (g_nstrobe - base >= 300) hit = 1'b1;
    end
    if (!hit) report_timeout("ff_300_strobes");
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    check("ff_abort_strobes", g_nstrobe - base, 300);
    check("ff_abort_cursor", {cursor_x, cursor_y}, {7'd0, 5'd0});
    reset = 1'b0;
    base = g_nstrobe;
    wait_idle(5000);
    check("reclear_strobes", g_nstrobe - base, 1200);
    check("reclear_cursor", {cursor_x, cursor_y}, {7'd0, 5'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
